uart_hamming_rx: RTL and testbench

- Serial receive stage directly downstream of the adaptive UART serdes TX path.
- Oversamples the serial line and captures one frame per codeword: a 12-bit Hamming(12,8) word plus an optional even-parity bit.
- Corrects single-bit errors, flags uncorrectable and framing faults, and presents a recovered 8-bit byte with a one-cycle valid strobe.

---
 rtl/uart_hamming_rx.sv | 207 ++++++++++++++++++++
 tb/tb_uart_hamming_rx.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/uart_hamming_rx.sv
// Oversampling UART receiver for Hamming(12,8) codewords with optional overall parity.
// Corrects single-bit errors, flags double/invalid syndromes, parity and framing faults.
module uart_hamming_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_serial,
  input  logic       par_en,
  output logic [7:0] data_8b_out,
  output logic       data_valid,
  output logic       corrected,
  output logic       uncorrectable,
  output logic       par_err,
  output logic       frame_err,
  output logic [3:0] syndrome,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT/2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;

  state_t        state_q, state_d;
  logic [1:0]    sync_q;
  logic [1:0]    fill_q;
  logic          seen_high_q, prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [11:0]   cw_q, cw_d;
  logic          pbit_q, pbit_d, pen_q, pen_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d, cor_q, cor_d, unc_q, unc_d;
  logic          perr_q, perr_d, ferr_q, ferr_d;
  logic [3:0]    syn_q, syn_d;

  logic rx_s, fall;
  assign rx_s = sync_q[1];

  // The synchronizer resets high, so its output is only trusted once real line
  // data has flushed through both stages; a start then needs a real high first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= 2'b11;
      fill_q      <= 2'd0;
      seen_high_q <= 1'b0;
      prev_q      <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], rx_serial};
      prev_q <= rx_s;
      if (fill_q != 2'd2) fill_q <= fill_q + 2'd1;
      else if (rx_s)      seen_high_q <= 1'b1;
    end
  end

  assign fall = seen_high_q & prev_q & ~rx_s;

  // Decode of the captured frame; only consumed at the stop-bit sample.
  logic [3:0]  dec_syn;
  logic        dec_ov, dec_fix, dec_unc, dec_perr, in_range;
  logic [11:0] dec_word;
  logic [7:0]  dec_data;

  always_comb begin
    dec_syn = 4'd0;
    for (int i = 0; i < 12; i++)
      if (cw_q[i]) dec_syn = dec_syn ^ 4'(i + 1);
    dec_ov   = (^cw_q) ^ pbit_q;
    in_range = (dec_syn != 4'd0) && (dec_syn <= 4'd12);
    dec_fix  = 1'b0;
    dec_unc  = 1'b0;
    dec_perr = 1'b0;
    if (!pen_q) begin
      dec_fix = in_range;
      dec_unc = (dec_syn > 4'd12);
    end else if (dec_syn == 4'd0) begin
      dec_perr = dec_ov;
    end else if (!dec_ov) begin
      dec_unc = 1'b1;
    end else if (in_range) begin
      dec_fix = 1'b1;
    end else begin
      dec_unc  = 1'b1;
      dec_perr = 1'b1;
    end
    dec_word = dec_fix ? (cw_q ^ (12'd1 << (dec_syn - 4'd1))) : cw_q;
    dec_data = {dec_word[11], dec_word[10], dec_word[9], dec_word[8],
                dec_word[6],  dec_word[5],  dec_word[4], dec_word[2]};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    cw_d    = cw_q;
    pbit_d  = pbit_q;
    pen_d   = pen_q;
    data_d  = data_q;
    cor_d   = cor_q;
    unc_d   = unc_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    syn_d   = syn_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = 4'd0;
        if (fall) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (!rx_s) begin
            pen_d   = par_en;
            pbit_d  = 1'b0;
            state_d = DATA;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          cw_d  = {rx_s, cw_q[11:1]};
          bit_d = bit_q + 4'd1;
          if (bit_q == 4'd11) state_d = pen_q ? PARITY : STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PARITY: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          pbit_d  = rx_s;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          data_d  = dec_data;
          cor_d   = dec_fix;
          unc_d   = dec_unc;
          perr_d  = dec_perr;
          ferr_d  = ~rx_s;
          syn_d   = dec_syn;
          valid_d = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= 4'd0;
      cw_q    <= 12'd0;
      pbit_q  <= 1'b0;
      pen_q   <= 1'b0;
      data_q  <= 8'd0;
      valid_q <= 1'b0;
      cor_q   <= 1'b0;
      unc_q   <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      syn_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      cw_q    <= cw_d;
      pbit_q  <= pbit_d;
      pen_q   <= pen_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      cor_q   <= cor_d;
      unc_q   <= unc_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      syn_q   <= syn_d;
    end
  end

  assign data_8b_out   = data_q;
  assign data_valid    = valid_q;
  assign corrected     = cor_q;
  assign uncorrectable = unc_q;
  assign par_err       = perr_q;
  assign frame_err     = ferr_q;
  assign syndrome      = syn_q;
  assign busy          = (state_q != IDLE) && (state_q != START);

endmodule

// File: tb/tb_uart_hamming_rx.sv
// Scoreboard bench for uart_hamming_rx: directed frames push expected results,
// a negedge monitor pops and compares on every data_valid.
module tb_uart_hamming_rx;
  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_serial = 1'b1;
  logic       par_en = 1'b0;
  logic [7:0] data_8b_out;
  logic       data_valid, corrected, uncorrectable, par_err, frame_err, busy;
  logic [3:0] syndrome;

  uart_hamming_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .rx_serial(rx_serial), .par_en(par_en),
    .data_8b_out(data_8b_out), .data_valid(data_valid), .corrected(corrected),
    .uncorrectable(uncorrectable), .par_err(par_err), .frame_err(frame_err),
    .syndrome(syndrome), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       cor, unc, perr, ferr;
    logic [3:0] syn;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   n_valid = 0;
  logic prev_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (data_valid) begin
      exp_t e;
      n_valid++;
      chk("valid_pulse_width", 32'(prev_valid), 32'd0);
      chk("busy_at_valid", 32'(busy), 32'd1);
      if (sb.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("data", 32'(data_8b_out), 32'(e.data));
        chk("corrected", 32'(corrected), 32'(e.cor));
        chk("uncorrectable", 32'(uncorrectable), 32'(e.unc));
        chk("par_err", 32'(par_err), 32'(e.perr));
        chk("frame_err", 32'(frame_err), 32'(e.ferr));
        chk("syndrome", 32'(syndrome), 32'(e.syn));
      end
    end
    prev_valid = data_valid;
  end

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Sends start, 12 codeword bits LSB (position 1) first, optional parity, stop.
  // par_en is flipped after the start bit to show mid-frame changes are ignored.
  task automatic send_frame(input logic [11:0] cw, input logic pen, input logic pbit,
                            input logic stopb, input exp_t e);
    sb.push_back(e);
    par_en = pen;
    rx_serial = 1'b0;
    clks(CPB);
    par_en = ~pen;
    for (int i = 0; i < 12; i++) begin
      rx_serial = cw[i];
      clks(CPB);
    end
    if (pen) begin
      rx_serial = pbit;
      clks(CPB);
    end
    rx_serial = stopb;
    clks(CPB);
    rx_serial = 1'b1;
    clks(2 * CPB);
  endtask

  function automatic exp_t mk(input logic [7:0] d, input logic c, input logic u,
                              input logic p, input logic f, input logic [3:0] s);
    exp_t e;
    e.data = d; e.cor = c; e.unc = u; e.perr = p; e.ferr = f; e.syn = s;
    return e;
  endfunction

  initial begin
    logic        busy_seen;
    logic [11:0] cw;
    cw = 12'hA27;

    clks(3);
    chk("reset_outputs",
        32'({data_8b_out, data_valid, corrected, uncorrectable, par_err, frame_err, syndrome, busy}),
        32'd0);
    rst_n = 1'b1;
    clks(2 * CPB);

    send_frame(12'hA27, 1'b0, 1'b0, 1'b1, mk(8'hA5, 0, 0, 0, 0, 4'd0));   // clean
    send_frame(12'hA07, 1'b1, 1'b0, 1'b1, mk(8'hA5, 1, 0, 0, 0, 4'd6));   // pos 6 flipped
    // positions 3 and 6 flipped: raw d0 and d2 cleared -> 0xA0
    send_frame(12'hA03, 1'b1, 1'b0, 1'b1, mk(8'hA0, 0, 1, 0, 0, 4'd5));
    send_frame(12'hA27, 1'b1, 1'b1, 1'b1, mk(8'hA5, 0, 0, 1, 0, 4'd0));   // parity bit only
    send_frame(12'hA27, 1'b0, 1'b0, 1'b0, mk(8'hA5, 0, 0, 0, 1, 4'd0));   // stop bit low
    send_frame(12'h226, 1'b0, 1'b0, 1'b1, mk(8'h25, 0, 1, 0, 0, 4'd13));  // pos 1,12 flipped
    send_frame(12'h226, 1'b1, 1'b1, 1'b1, mk(8'h25, 0, 1, 1, 0, 4'd13));  // syn 13 with ov
    send_frame(12'h227, 1'b0, 1'b0, 1'b1, mk(8'hA5, 1, 0, 0, 0, 4'd12));  // pos 12 flipped

    // Short low glitch: rejected at start sample, results untouched.
    busy_seen = 1'b0;
    rx_serial = 1'b0;
    for (int i = 0; i < CPB / 4; i++) begin
      @(negedge clk); busy_seen |= busy;
    end
    rx_serial = 1'b1;
    for (int i = 0; i < 3 * CPB; i++) begin
      @(negedge clk); busy_seen |= busy;
    end
    chk("glitch_busy", 32'(busy_seen), 32'd0);
    chk("glitch_hold_data", 32'(data_8b_out), 32'hA5);
    chk("glitch_hold_syn", 32'(syndrome), 32'd12);
    clks(1);

    // Reset during codeword bit 5 (position 5 is 0 in 0xA27).
    rx_serial = 1'b0;
    clks(CPB);
    for (int i = 0; i < 4; i++) begin
      rx_serial = cw[i];
      clks(CPB);
    end
    rx_serial = cw[4];
    clks(CPB / 2);
    rst_n = 1'b0;
    clks(3);
    chk("midframe_reset_outputs",
        32'({data_8b_out, data_valid, corrected, uncorrectable, par_err, frame_err, syndrome, busy}),
        32'd0);
    rst_n = 1'b1;
    busy_seen = 1'b0;
    for (int i = 0; i < 4 * CPB; i++) begin
      @(negedge clk); busy_seen |= busy;
    end
    chk("low_after_reset_busy", 32'(busy_seen), 32'd0);
    clks(1);
    rx_serial = 1'b1;
    clks(2 * CPB);
    send_frame(12'hA27, 1'b0, 1'b0, 1'b1, mk(8'hA5, 0, 0, 0, 0, 4'd0));

    for (int i = 0; i < 1000 && sb.size() != 0; i++) @(posedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    chk("valid_count", 32'(n_valid), 32'd9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end
endmodule
